// File: rtl/onehot_rr_sched.sv
// Round-robin owner of a one-hot N:1 mux select. Each ownership is followed by
// one all-zero select cycle, so two select bits are never high at once.

module onehot_rr_lane (
  input  logic a,
  input  logic sel,
  output logic y
);
  assign y = a & sel;
endmodule

module onehot_rr_sched #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  input  logic [NUM_REQ-1:0] a_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               busy_o,
  output logic               y_o,
  output logic               y_valid_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr, ptr_nxt, own, own_nxt;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt, lane_y;
  logic [PW-1:0]        pick, idx;
  logic                 found, rel;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    onehot_rr_lane u_lane (.a(a_i[i]), .sel(gnt_o[i]), .y(lane_y[i]));
  end

  // Cyclic scan starting at ptr; the first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rel = done_i[own] | ~req_i[own] | (hold_cnt == HW'(MAX_HOLD));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    own_nxt   = own;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt_o;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = GRANT;
          own_nxt       = pick;
          hold_nxt      = HW'(1);
          gnt_nxt       = '0;
          gnt_nxt[pick] = 1'b1;
        end
      end
      GRANT: begin
        // Release always drops to an all-zero select for one cycle.
        if (rel) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          hold_nxt  = '0;
          ptr_nxt   = (own == PW'(NUM_REQ - 1)) ? '0 : own + PW'(1);
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      own       <= '0;
      hold_cnt  <= '0;
      gnt_o     <= '0;
      busy_o    <= 1'b0;
      y_o       <= 1'b0;
      y_valid_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      own       <= own_nxt;
      hold_cnt  <= hold_nxt;
      gnt_o     <= gnt_nxt;
      busy_o    <= |gnt_nxt;
      y_o       <= |lane_y;
      y_valid_o <= |gnt_o;
    end
  end
endmodule

// File: tb/tb_onehot_rr_sched.sv
// Bench for onehot_rr_sched: directed scenarios plus random traffic, compared
// every cycle against an integer-level round-robin model.

module tb_onehot_rr_sched;
  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_i, done_i, a_i;
  logic [N-1:0] gnt_o;
  logic         busy_o, y_o, y_valid_o;

  onehot_rr_sched #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .done_i(done_i), .a_i(a_i),
    .gnt_o(gnt_o), .busy_o(busy_o), .y_o(y_o), .y_valid_o(y_valid_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  // model: owner index (-1 = nobody), pointer, hold count, data outputs
  int           m_own = -1, m_ptr = 0, m_hold = 0;
  logic         m_y = 1'b0, m_yv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_own >= 0) g[m_own] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    logic [N-1:0] g;
    g = m_gnt();
    if (reset) begin
      m_own = -1; m_ptr = 0; m_hold = 0; m_y = 1'b0; m_yv = 1'b0;
    end else begin
      m_y  = |(a_i & g);
      m_yv = |g;
      if (m_own < 0) begin
        for (int k = 0; k < N; k++) begin
          if (req_i[(m_ptr + k) % N]) begin
            m_own = (m_ptr + k) % N; m_hold = 1; break;
          end
        end
      end else if (done_i[m_own] || !req_i[m_own] || m_hold == MH) begin
        m_ptr = (m_own + 1) % N; m_own = -1; m_hold = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt", 32'(gnt_o), 32'(m_gnt()));
    chk("busy", 32'(busy_o), 32'(m_own >= 0));
    chk("y", 32'(y_o), 32'(m_y));
    chk("y_valid", 32'(y_valid_o), 32'(m_yv));
    chk("onehot0", 32'($onehot0(gnt_o)), 32'd1);
    chk("busy_eq_or", 32'(busy_o), 32'(|gnt_o));
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    repeat (cyc) step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_i = '0; done_i = '0; a_i = '0;

    // reset with all requesting: outputs stay 0, first grant to requester 0
    req_i = 4'b1111;
    do_reset(2);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_yv", 32'(y_valid_o), 32'd0);
    step();
    chk("rst_first_gnt", 32'(gnt_o), 32'b0001);

    // single requester with data and done pulse
    req_i = '0;
    do_reset(1);
    req_i = 4'b0100; a_i = 4'b0100;
    step(); chk("single_gnt", 32'(gnt_o), 32'b0100);
    step(); chk("single_y", 32'({y_o, y_valid_o}), 32'b11);
    step(); step();
    done_i = 4'b0100;
    step(); done_i = '0;
    chk("single_rel", 32'(gnt_o), 32'd0);
    req_i = '0;
    step(); chk("single_yv0", 32'(y_valid_o), 32'd0);

    // saturation: period 36, expected pattern built from constants
    do_reset(1);
    req_i = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      logic [N-1:0] e;
      int pos;
      step();
      pos = c % 36;
      e = '0;
      if (pos % 9 != 8) e[pos / 9] = 1'b1;
      chk("sat", 32'(gnt_o), 32'(e));
    end

    // pointer wrap: release owner 2 then 1011 -> owners 3,0,1
    do_reset(1);
    req_i = 4'b0100; step(); step();
    req_i = 4'b0000; step();
    req_i = 4'b1011;
    step(); chk("wrap_o3", 32'(gnt_o), 32'b1000);
    done_i = 4'b1000; step(); done_i = '0;
    step(); chk("wrap_o0", 32'(gnt_o), 32'b0001);
    done_i = 4'b0001; step(); done_i = '0;
    step(); chk("wrap_o1", 32'(gnt_o), 32'b0010);

    // foreign done ignored, then owner drops request
    done_i = 4'b0001; step(); done_i = '0;
    chk("foreign_done", 32'(gnt_o), 32'b0010);
    req_i = 4'b0001; step();
    chk("drop_rel", 32'(gnt_o), 32'd0);
    step(); chk("drop_next0", 32'(gnt_o), 32'b0001);

    // reset mid-grant: owner 3 regranted with fresh hold count
    do_reset(1);
    req_i = 4'b1000;
    repeat (5) step();
    do_reset(1);
    chk("midrst_gnt", 32'(gnt_o), 32'd0);
    repeat (MH + 2) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) req_i[i] = ~req_i[i];
      done_i = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      a_i    = N'($urandom);
      reset  = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
